clock_gen: RTL and testbench

//   Programmable clock divider producing the serial clock (out_clk) for the SPI master.
//   A divisor is latched on a load strobe. While enabled, out_clk toggles every
//   max(divisor,1) system-clock cycles. When disabled, out_clk idles low (CPOL=0).

---
 rtl/spi_pkg.sv | 11 +
 rtl/clock_gen.sv | 60 ++++++
 tb/tb_clock_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Constants and types shared by the SPI master blocks.
// The serial-clock divider and the control FSM both size their divisor from these.
package spi_pkg;

    localparam int          DIV_W      = 8;
    localparam logic [7:0]  RESET_DIV  = 8'h02;
    localparam logic        IDLE_LEVEL = 1'b0;

    typedef logic [DIV_W-1:0] div_t;

endpackage

// File: rtl/clock_gen.sv
// Programmable serial-clock divider for the SPI master.
// The output toggles every max(divisor,1) cycles while enabled and idles low otherwise.
module clock_gen
    import spi_pkg::*;
#(
    parameter int               P_DIV_W      = DIV_W,
    parameter logic [P_DIV_W-1:0] P_RESET_DIV = P_DIV_W'(RESET_DIV),
    parameter logic             P_IDLE_LEVEL = IDLE_LEVEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_DIV_W-1:0] divisor,
    input  logic               ld_divisor,
    input  logic               En,
    output logic               out_clk
);

    logic [P_DIV_W-1:0] div_q, div_d;
    logic [P_DIV_W-1:0] cnt_q, cnt_d;
    logic               out_q, out_d;
    logic [P_DIV_W-1:0] half;
    logic [P_DIV_W-1:0] half_last;

    // A zero divisor is treated as one so the output can never stall.
    assign half      = (div_q == '0) ? P_DIV_W'(1) : div_q;
    assign half_last = half - P_DIV_W'(1);

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (ld_divisor) begin
            div_d = divisor;
            cnt_d = '0;
        end else if (!En) begin
            cnt_d = '0;
            out_d = P_IDLE_LEVEL;
        end else if (cnt_q == half_last) begin
            cnt_d = '0;
            out_d = ~out_q;
        end else begin
            cnt_d = cnt_q + P_DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= P_RESET_DIV;
            cnt_q <= '0;
            out_q <= P_IDLE_LEVEL;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_clk = out_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: a waveform model feeds a scoreboard per edge,
// plus first-rise latency and period measurements for several divisors.
`timescale 1ns/1ps
module tb_clock_gen;

    logic       clk;
    logic       rst;
    logic [7:0] divisor;
    logic       ld_divisor;
    logic       En;
    logic       out_clk;

    int vectors;
    int miscompares;

    logic exp_q[$];

    // Reference model state: level at the last restart and en-edges since it.
    int   m_div;
    logic m_base;
    int   m_steps;
    logic m_out;

    int   en_cnt;
    int   first_rise;
    logic prev_out;
    realtime rise_t[$];

    clock_gen dut (
        .clk        (clk),
        .rst        (rst),
        .divisor    (divisor),
        .ld_divisor (ld_divisor),
        .En         (En),
        .out_clk    (out_clk)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic apply(input logic r, input logic l, input logic [7:0] d, input logic e);
        logic expv;
        int   h;
        @(negedge clk);
        rst        = r;
        ld_divisor = l;
        divisor    = d;
        En         = e;
        if (!r) begin
            m_div = 2; m_base = 1'b0; m_steps = 0; m_out = 1'b0;
        end else if (l) begin
            m_div = int'(d); m_base = m_out; m_steps = 0;
        end else if (!e) begin
            m_base = 1'b0; m_steps = 0; m_out = 1'b0;
        end else begin
            m_steps++;
            h = (m_div == 0) ? 1 : m_div;
            m_out = m_base ^ (((m_steps / h) % 2) == 1);
            en_cnt++;
        end
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        vectors++;
        assert (out_clk === expv) else begin
            miscompares++;
            $error("FAIL out_clk t=%0t observed=%b expected=%b", $time, out_clk, expv);
        end
        $display("t=%0t rst=%b ld=%b div=%h en=%b out_clk=%b exp=%b",
                 $time, r, l, d, e, out_clk, expv);
        if (out_clk === 1'b1 && prev_out === 1'b0) begin
            if (first_rise < 0) first_rise = en_cnt;
            rise_t.push_back($realtime);
        end
        prev_out = out_clk;
    endtask

    // Run enabled for n edges from idle; check first-rise en-edge and period.
    task automatic measure(input logic [7:0] d, input int half_exp, input int n, input int period_ns);
        int per;
        en_cnt     = 0;
        first_rise = -1;
        rise_t.delete();
        for (int i = 0; i < n; i++) apply(1'b1, 1'b0, d, 1'b1);
        vectors++;
        assert (first_rise === half_exp) else begin
            miscompares++;
            $error("FAIL first_rise observed=%0d expected=%0d", first_rise, half_exp);
        end
        per = (rise_t.size() >= 2) ? int'(rise_t[1] - rise_t[0]) : -1;
        vectors++;
        assert (per === period_ns) else begin
            miscompares++;
            $error("FAIL period observed=%0d expected=%0d", per, period_ns);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_div = 2; m_base = 1'b0; m_steps = 0; m_out = 1'b0;
        en_cnt = 0; first_rise = -1; prev_out = 1'b0;
        rst = 1'b0; ld_divisor = 1'b0; divisor = 8'h00; En = 1'b0;

        // 1: reset, then idle with En low
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 8'h00, 1'b0);

        // 2: load 4, then run with a stray divisor value and no load
        apply(1'b1, 1'b1, 8'h04, 1'b0);
        measure(8'hFF, 4, 20, 160);

        // 3: reset defaults, load 2 and 5
        apply(1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h02, 1'b0);
        measure(8'h00, 2, 12, 80);
        apply(1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h05, 1'b0);
        measure(8'h00, 5, 30, 200);

        // 4: divisor 0 and 1 both give clk/2
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h00, 1'b0);
        measure(8'h00, 1, 8, 40);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h01, 1'b0);
        measure(8'h00, 1, 8, 40);

        // 5: drop En mid-high, re-enable, reset during run
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 8'h00, 1'b1);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        measure(8'h00, 3, 14, 120);
        apply(1'b0, 1'b0, 8'h00, 1'b1);
        measure(8'h00, 2, 12, 80);

        // 6: reload while running holds the level and restarts the count
        apply(1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 8'h04, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 8'h00, 1'b1);
        apply(1'b1, 1'b1, 8'h02, 1'b1);
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
